ppu_ctrl: RTL

PPU_CTRL -- requirements
Module: ppu_ctrl

---
 rtl/ppu_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ppu_ctrl.sv
// Job-level controller for the post-processing unit: takes a job configuration, feeds partial sums to
// the PPU in bypass or maxpool mode, and registers the 8-bit results onto a ready/valid output stream.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module ppu_ctrl #(
    parameter int DATA_BITS = `DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [5:0]           cfg_scaling_factor,
    input  logic                 cfg_relu_en,
    input  logic                 cfg_pool_en,
    input  logic [2:0]           cfg_pool_k,
    input  logic [15:0]          cfg_num_out,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic [DATA_BITS-1:0] ppu_data_in,
    output logic [5:0]           ppu_scaling_factor,
    output logic                 ppu_relu_en,
    output logic                 ppu_maxpool_en,
    output logic                 ppu_maxpool_init,
    output logic                 ppu_relu_sel,
    input  logic [7:0]           ppu_data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, RUN, CAPTURE, FLUSH} state_e;

    state_e      state_q, state_d;
    logic [5:0]  scale_q, scale_d;
    logic        relu_q, relu_d;
    logic        pool_q, pool_d;
    logic [2:0]  k_q, k_d;
    logic [15:0] num_out_q, num_out_d;
    logic [15:0] out_cnt_q, out_cnt_d;
    logic [2:0]  win_cnt_q, win_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        free;
    logic        capture;

    always_comb begin
        state_d          = state_q;
        scale_d          = scale_q;
        relu_d           = relu_q;
        pool_d           = pool_q;
        k_d              = k_q;
        num_out_d        = num_out_q;
        out_cnt_d        = out_cnt_q;
        win_cnt_d        = win_cnt_q;
        out_data_d       = out_data_q;
        out_valid_d      = out_valid_q && !out_ready;
        cfg_ready        = 1'b0;
        in_ready         = 1'b0;
        ppu_maxpool_en   = 1'b0;
        ppu_maxpool_init = 1'b0;
        ppu_relu_sel     = 1'b0;
        done             = 1'b0;
        free             = !out_valid_q || out_ready;
        capture          = 1'b0;

        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    scale_d   = cfg_scaling_factor;
                    relu_d    = cfg_relu_en;
                    pool_d    = cfg_pool_en;
                    k_d       = (cfg_pool_k == 3'd0) ? 3'd1 : cfg_pool_k;
                    num_out_d = cfg_num_out;
                    out_cnt_d = 16'd0;
                    win_cnt_d = 3'd0;
                    state_d   = (cfg_num_out == 16'd0) ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (pool_q) begin
                    // Pool windows always accept; output backpressure is absorbed in CAPTURE.
                    in_ready = 1'b1;
                    if (in_valid) begin
                        ppu_maxpool_en   = 1'b1;
                        ppu_maxpool_init = (win_cnt_q == 3'd0);
                        if (win_cnt_q == k_q - 3'd1) begin
                            win_cnt_d = 3'd0;
                            state_d   = CAPTURE;
                        end else begin
                            win_cnt_d = win_cnt_q + 3'd1;
                        end
                    end
                end else begin
                    in_ready = free;
                    capture  = in_valid && free;
                end
            end
            CAPTURE: begin
                ppu_relu_sel = 1'b1;
                capture      = free;
            end
            FLUSH: begin
                if (free) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            out_data_d  = ppu_data_out;
            out_valid_d = 1'b1;
            out_cnt_d   = out_cnt_q + 16'd1;
            state_d     = (out_cnt_q + 16'd1 == num_out_q) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            scale_q     <= 6'd0;
            relu_q      <= 1'b0;
            pool_q      <= 1'b0;
            k_q         <= 3'd0;
            num_out_q   <= 16'd0;
            out_cnt_q   <= 16'd0;
            win_cnt_q   <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            scale_q     <= scale_d;
            relu_q      <= relu_d;
            pool_q      <= pool_d;
            k_q         <= k_d;
            num_out_q   <= num_out_d;
            out_cnt_q   <= out_cnt_d;
            win_cnt_q   <= win_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign ppu_data_in        = in_data;
    assign ppu_scaling_factor = scale_q;
    assign ppu_relu_en        = relu_q;
    assign out_valid          = out_valid_q;
    assign out_data           = out_data_q;

endmodule
